data_mem_ctrl: RTL

Parametrised data memory for the processor's load/store path, replacing the fixed ten-word, combinationally-read memory. Adds a valid/ready request/response handshake, registered reads, per-byte write strobes, out-of-range detection, and a memory-mapped display register. It sits between the core's memory stage and the board display driver.

---
 rtl/data_mem_pkg.sv | 6 +
 rtl/data_mem_if.sv | 28 ++
 rtl/data_mem_array.sv | 25 ++
 rtl/data_mem_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM state type and byte-lane constants for the data memory controller
package data_mem_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int BYTES = DEF_DATA_W / 8;
    typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: request/response handshake between the core memory stage and the data memory
interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W/8-1:0] req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [DATA_W-1:0] display;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, display
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, display
    );
endinterface

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH x DATA_W storage, byte-strobed write port and registered read port, no reset
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked load/store controller with decode, display register and registered responses.
// Define DATA_MEM_BYTE_EN to honour req_be; otherwise every store writes the full word.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = 16,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] DISP_ADDR = '1
) (
    input logic clk,
    input logic rst,
    data_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    state_t state_q, state_d;
    logic [DATA_W-1:0] disp_q, disp_d, data_q, data_d, mem_rdata;
    logic sel_q, sel_d, err_q, err_d;
    logic [NB-1:0] be_eff;

`ifdef DATA_MEM_BYTE_EN
    assign be_eff = bus.req_be;
`else
    logic unused_be;
    assign unused_be = ^bus.req_be;
    assign be_eff = '1;
`endif

    logic accept, is_disp, in_rng;
    assign accept  = bus.req_valid && state_q == IDLE;
    assign is_disp = bus.req_addr == DISP_ADDR;
    assign in_rng  = !is_disp && bus.req_addr < ADDR_W'(DEPTH);

    data_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (accept && bus.req_write && in_rng),
        .re    (accept && !bus.req_write && in_rng),
        .addr  (bus.req_addr[AW-1:0]),
        .be    (be_eff),
        .wdata (bus.req_wdata),
        .rdata (mem_rdata)
    );

    // Storage loads are served straight from the array's read register (sel_q); everything else from data_q.
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = err_q;
        if (accept) begin
            state_d = RESP;
            err_d   = !is_disp && !in_rng;
            sel_d   = !bus.req_write && in_rng;
            data_d  = (!bus.req_write && is_disp) ? disp_q : '0;
            for (int i = 0; i < NB; i++)
                if (bus.req_write && is_disp && be_eff[i]) disp_d[8*i +: 8] = bus.req_wdata[8*i +: 8];
        end else if (state_q == RESP && bus.resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            disp_q  <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = sel_q ? mem_rdata : data_q;
    assign bus.resp_err   = err_q;
    assign bus.display    = disp_q;
endmodule
